// File: rtl/rgbw_pwm_generator.sv
// Four-channel 8-bit PWM with a prescaled tick, per-period shadow duties and optional phase stagger.
// Outputs are registered one clock behind cnt/shadow; there is no backpressure, en=0 idles the block.
module rgbw_pwm_generator #(
   parameter bit STAGGER = 1'b1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       en,
   input  logic [7:0] prescale,
   input  logic [7:0] red_in,
   input  logic [7:0] green_in,
   input  logic [7:0] blue_in,
   input  logic [7:0] white_in,
   output logic       pwm_r,
   output logic       pwm_g,
   output logic       pwm_b,
   output logic       pwm_w,
   output logic       period_start
);

   localparam logic [7:0] OFF_R = 8'd0;
   localparam logic [7:0] OFF_G = STAGGER ? 8'd64  : 8'd0;
   localparam logic [7:0] OFF_B = STAGGER ? 8'd128 : 8'd0;
   localparam logic [7:0] OFF_W = STAGGER ? 8'd192 : 8'd0;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t     state;
   state_t     state_nxt;

   logic [7:0] pre_cnt;
   logic [7:0] cnt;
   logic [7:0] sh_r;
   logic [7:0] sh_g;
   logic [7:0] sh_b;
   logic [7:0] sh_w;

   logic       tick;
   logic       load;
   logic [7:0] pre_nxt;
   logic [7:0] cnt_nxt;
   logic [3:0] pwm_nxt;
   logic       ps_nxt;

   // Duty 0 and 255 are forced so that full-off and full-on hold across the wrap.
   function automatic logic duty_bit(input logic [7:0] c, input logic [7:0] off,
                                     input logic [7:0] duty);
      logic [7:0] phase;
      phase = c + off;
      if (duty == 8'hFF) begin
         return 1'b1;
      end
      if (duty == 8'h00) begin
         return 1'b0;
      end
      return (phase < duty);
   endfunction

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (en)  state_nxt = RUN;
         RUN:     if (!en) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      tick    = 1'b0;
      load    = 1'b0;
      pre_nxt = 8'd0;
      cnt_nxt = 8'd0;
      pwm_nxt = 4'b0000;
      ps_nxt  = 1'b0;
      case (state)
         IDLE: begin
            if (en) begin
               load   = 1'b1;
               ps_nxt = 1'b1;
            end
         end
         RUN: begin
            // >= rather than == so a prescale drop below pre_cnt ticks at once.
            tick = (pre_cnt >= prescale);
            load = tick && (cnt == 8'hFF);
            if (en) begin
               pre_nxt = tick ? 8'd0 : pre_cnt + 8'd1;
               cnt_nxt = tick ? cnt + 8'd1 : cnt;
               pwm_nxt = {duty_bit(cnt, OFF_R, sh_r), duty_bit(cnt, OFF_G, sh_g),
                          duty_bit(cnt, OFF_B, sh_b), duty_bit(cnt, OFF_W, sh_w)};
               ps_nxt  = load;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pre_cnt      <= 8'd0;
         cnt          <= 8'd0;
         sh_r         <= 8'd0;
         sh_g         <= 8'd0;
         sh_b         <= 8'd0;
         sh_w         <= 8'd0;
         pwm_r        <= 1'b0;
         pwm_g        <= 1'b0;
         pwm_b        <= 1'b0;
         pwm_w        <= 1'b0;
         period_start <= 1'b0;
      end else begin
         pre_cnt <= pre_nxt;
         cnt     <= cnt_nxt;
         if (load) begin
            sh_r <= red_in;
            sh_g <= green_in;
            sh_b <= blue_in;
            sh_w <= white_in;
         end
         {pwm_r, pwm_g, pwm_b, pwm_w} <= pwm_nxt;
         period_start                 <= ps_nxt;
      end
   end

endmodule

// File: tb/tb_rgbw_pwm_generator.sv
// Bench for rgbw_pwm_generator: aligned and staggered instances share stimulus and are
// compared every clock against a period/time-index model of the PWM.
module tb_rgbw_pwm_generator;

   logic       clk = 1'b0;
   logic       reset;
   logic       en;
   logic [7:0] prescale;
   logic [7:0] red_in, green_in, blue_in, white_in;
   logic       r0, g0, b0, w0, ps0;
   logic       r1, g1, b1, w1, ps1;

   int checks   = 0;
   int failures = 0;

   bit         m_run = 1'b0;
   int         m_t   = 0;
   int         m_p   = 0;
   int         m_sh[4];
   int         cyc   = 0;
   int         last_rise[4];
   int         r_rises = 0;
   logic [3:0] prev1 = 4'b0000;
   int         mlen;
   int         mhi[4];

   always #5 clk = ~clk;

   rgbw_pwm_generator #(.STAGGER(1'b0)) dut0 (
      .clk(clk), .reset(reset), .en(en), .prescale(prescale),
      .red_in(red_in), .green_in(green_in), .blue_in(blue_in), .white_in(white_in),
      .pwm_r(r0), .pwm_g(g0), .pwm_b(b0), .pwm_w(w0), .period_start(ps0)
   );

   rgbw_pwm_generator #(.STAGGER(1'b1)) dut1 (
      .clk(clk), .reset(reset), .en(en), .prescale(prescale),
      .red_in(red_in), .green_in(green_in), .blue_in(blue_in), .white_in(white_in),
      .pwm_r(r1), .pwm_g(g1), .pwm_b(b1), .pwm_w(w1), .period_start(ps1)
   );

   initial begin
      #2_000_000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   function automatic logic ref_bit(int c, int duty, int off);
      int phase;
      phase = (c + off) % 256;
      if (duty == 255) return 1'b1;
      if (duty == 0)   return 1'b0;
      return (phase < duty);
   endfunction

   function automatic logic [7:0] rnd_duty();
      case ($urandom_range(0, 5))
         0:       return 8'd0;
         1:       return 8'd255;
         2:       return 8'd1;
         3:       return 8'd254;
         default: return 8'($urandom_range(0, 255));
      endcase
   endfunction

   task automatic check5(string tag, logic [4:0] obs, logic [4:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s t=%0d observed=%b expected=%b", tag, cyc, obs, exp);
      end
   endtask

   task automatic check_int(string tag, int obs, int exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // One clock: model advances on what the DUT sampled at this edge, then both DUTs are compared.
   task automatic step();
      bit         rs, es;
      int         ps_s, len, c;
      int         ins[4];
      bit         bnd;
      logic [4:0] e0, e1;
      rs = reset; es = en; ps_s = int'(prescale);
      ins[0] = int'(red_in); ins[1] = int'(green_in);
      ins[2] = int'(blue_in); ins[3] = int'(white_in);
      @(posedge clk);
      #1;
      cyc++;
      e0 = 5'b0; e1 = 5'b0;
      if (rs) begin
         m_run = 1'b0;
      end else if (!m_run) begin
         if (es) begin
            m_run = 1'b1; m_t = 0; m_p = ps_s; m_sh = ins;
            e0 = 5'b00001; e1 = 5'b00001;
         end
      end else begin
         len = 256 * (m_p + 1);
         c   = (m_t / (m_p + 1)) % 256;
         bnd = ((m_t + 1) % len) == 0;
         if (es) begin
            e0 = {ref_bit(c, m_sh[0], 0), ref_bit(c, m_sh[1], 0),
                  ref_bit(c, m_sh[2], 0), ref_bit(c, m_sh[3], 0), bnd};
            e1 = {ref_bit(c, m_sh[0], 0), ref_bit(c, m_sh[1], 64),
                  ref_bit(c, m_sh[2], 128), ref_bit(c, m_sh[3], 192), bnd};
            m_t++;
         end else begin
            m_run = 1'b0;
         end
         if (bnd) m_sh = ins;
      end
      check5("aligned_out", {r0, g0, b0, w0, ps0}, e0);
      check5("stagger_out", {r1, g1, b1, w1, ps1}, e1);
      if (r1 && !prev1[3]) begin last_rise[0] = cyc; r_rises++; end
      if (g1 && !prev1[2]) last_rise[1] = cyc;
      if (b1 && !prev1[1]) last_rise[2] = cyc;
      if (w1 && !prev1[0]) last_rise[3] = cyc;
      prev1 = {r1, g1, b1, w1};
   endtask

   task automatic steps(int n);
      for (int i = 0; i < n; i++) step();
   endtask

   // Window of one period as seen on the pins: from the clock after period_start up to the next one.
   task automatic measure(int change_at, logic [7:0] new_red);
      int n;
      n = 0;
      while (!ps0 && n < 5000) begin step(); n++; end
      checks++;
      assert (ps0 === 1'b1) else begin
         failures++;
         $error("FAIL period_start_wait observed=%b expected=1", ps0);
      end
      mlen = 0;
      for (int k = 0; k < 4; k++) mhi[k] = 0;
      do begin
         step();
         mlen++;
         mhi[0] += int'(r0); mhi[1] += int'(g0); mhi[2] += int'(b0); mhi[3] += int'(w0);
         if (mlen == change_at) red_in = new_red;
      end while (!ps0 && mlen < 5000);
   endtask

   initial begin
      int n, lim;
      reset = 1'b1; en = 1'b0; prescale = 8'd0;
      red_in = 8'd0; green_in = 8'd0; blue_in = 8'd0; white_in = 8'd0;
      #2;
      steps(3);
      reset = 1'b0;
      steps(3);

      // Aligned duty counts, constant off/on channels over three periods
      red_in = 8'd64; green_in = 8'd100; blue_in = 8'd0; white_in = 8'd255;
      en = 1'b1;
      for (int p = 0; p < 3; p++) begin
         measure(-1, 8'd0);
         check_int("p0_period_len", mlen, 256);
         check_int("p0_red_high", mhi[0], 64);
         check_int("p0_green_high", mhi[1], 100);
         check_int("p0_blue_off", mhi[2], 0);
         check_int("p0_white_on", mhi[3], 256);
      end

      // Mid-period duty change takes effect only at the next period
      measure(100, 8'd200);
      check_int("change_cur_red", mhi[0], 64);
      measure(-1, 8'd0);
      check_int("change_next_red", mhi[0], 200);

      // Prescale 3
      en = 1'b0; steps(2);
      prescale = 8'd3; green_in = 8'd128;
      en = 1'b1;
      measure(-1, 8'd0);
      measure(-1, 8'd0);
      check_int("pre3_period_len", mlen, 1024);
      check_int("pre3_green_high", mhi[1], 512);
      check_int("pre3_red_high", mhi[0], 800);

      // Staggered rising edges
      en = 1'b0; steps(2);
      prescale = 8'd0;
      red_in = 8'd128; green_in = 8'd128; blue_in = 8'd128; white_in = 8'd128;
      r_rises = 0;
      en = 1'b1;
      n = 0;
      while (r_rises < 2 && n < 2000) begin step(); n++; end
      check_int("stagger_r_rises", r_rises, 2);
      check_int("stagger_g_lead", last_rise[0] - last_rise[1], 64);
      check_int("stagger_b_lead", last_rise[0] - last_rise[2], 128);
      check_int("stagger_w_lead", last_rise[0] - last_rise[3], 192);

      // Asynchronous reset mid-period, restart with en held
      en = 1'b0; steps(2);
      white_in = 8'd255;
      en = 1'b1;
      n = 0;
      while (!(m_run && m_t == 150) && n < 2000) begin step(); n++; end
      check_int("reach_cnt150", m_t, 150);
      check5("pre_reset_white", {w0, w1, 3'b000}, 5'b11000);
      reset = 1'b1;
      #1;
      m_run = 1'b0;
      check5("async_reset_aligned", {r0, g0, b0, w0, ps0}, 5'b0);
      check5("async_reset_stagger", {r1, g1, b1, w1, ps1}, 5'b0);
      steps(2);
      reset = 1'b0;
      step();
      check_int("restart_ps", int'(ps0), 1);

      // Randomised segments, some ending with en falling on the wrap tick
      for (int seg = 0; seg < 20; seg++) begin
         en = 1'b0;
         steps($urandom_range(1, 4));
         prescale = 8'($urandom_range(0, 2));
         red_in = rnd_duty(); green_in = rnd_duty(); blue_in = rnd_duty(); white_in = rnd_duty();
         en = 1'b1;
         n = $urandom_range(50, 1000);
         for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 63) == 0) begin
               case ($urandom_range(0, 3))
                  0:       red_in   = rnd_duty();
                  1:       green_in = rnd_duty();
                  2:       blue_in  = rnd_duty();
                  default: white_in = rnd_duty();
               endcase
            end
            step();
         end
         if ($urandom_range(0, 1) == 1) begin
            lim = 0;
            while (m_run && ((m_t + 1) % (256 * (m_p + 1))) != 0 && lim < 5000) begin
               step(); lim++;
            end
         end
      end
      en = 1'b0;
      steps(3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
